// File: rtl/carpark_pkg.sv
// Shared types and default constants for the car-park occupancy and gate controller.
package carpark_pkg;

  typedef enum logic [1:0] {
    G_IDLE  = 2'b00,
    G_OPEN  = 2'b01,
    G_CLOSE = 2'b10
  } gate_state_t;

  localparam int DEF_CAPACITY   = 15;
  localparam int DEF_CNT_W      = 4;
  localparam int DEF_GATE_TICKS = 8;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int width_for(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/occ_counter.sv
// Saturating occupancy counter with full/empty decode.
// CARPARK_ERR_EN adds a sticky over/underflow flag; otherwise err is tied low.
module occ_counter
  import carpark_pkg::*;
#(
  parameter int CAPACITY = DEF_CAPACITY,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam logic [CNT_W-1:0] CAP_C  = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;

  // Next count: simultaneous inc/dec cancel, both ends hold.
  always_comb begin
    count_nxt_s = count_r;
    case ({inc, dec})
      2'b10: begin
        if (count_r == CAP_C) begin
          count_nxt_s = count_r;
        end else begin
          count_nxt_s = count_r + ONE_C;
        end
      end
      2'b01: begin
        if (count_r == ZERO_C) begin
          count_nxt_s = count_r;
        end else begin
          count_nxt_s = count_r - ONE_C;
        end
      end
      default: count_nxt_s = count_r;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= ZERO_C;
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign count = count_r;
  assign full  = (count_r == CAP_C);
  assign empty = (count_r == ZERO_C);

`ifdef CARPARK_ERR_EN
  logic err_r;
  logic sat_s;

  assign sat_s = (inc && !dec && (count_r == CAP_C)) ||
                 (dec && !inc && (count_r == ZERO_C));

  // Sticky saturation flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | sat_s;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/carpark_gate_ctrl.sv
// Car-park occupancy and entry-barrier controller: gate FSM, open timer and reject divider.
// Optional sticky err flag via CARPARK_ERR_EN (implemented in occ_counter).
module carpark_gate_ctrl
  import carpark_pkg::*;
#(
  parameter int CAPACITY   = DEF_CAPACITY,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int GATE_TICKS = DEF_GATE_TICKS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entered,
  input  logic             exited,
  input  logic             entry_req,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             gate_open,
  output logic             reject,
  output logic             timeout,
  output logic             err
);

  localparam int                TMR_W    = width_for(GATE_TICKS);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(GATE_TICKS - 1);

  gate_state_t      state_r, state_nxt_s;
  logic [TMR_W-1:0] timer_r, timer_nxt_s;
  logic [1:0]       rej_div_r, rej_div_nxt_s;
  logic             rej_act_r, rej_act_nxt_s;
  logic             gate_open_r, reject_r, timeout_r;
  logic             reject_nxt_s, timeout_nxt_s;
  logic             full_s, empty_s;

  occ_counter #(
    .CAPACITY (CAPACITY),
    .CNT_W    (CNT_W)
  ) u_occ (
    .clk   (clk),
    .reset (reset),
    .inc   (entered),
    .dec   (exited),
    .count (count),
    .full  (full_s),
    .empty (empty_s),
    .err   (err)
  );

  // Gate next-state, timer and reject divider; full check uses the registered count.
  always_comb begin
    state_nxt_s   = state_r;
    timer_nxt_s   = timer_r;
    rej_div_nxt_s = 2'd0;
    rej_act_nxt_s = 1'b0;
    reject_nxt_s  = 1'b0;
    timeout_nxt_s = 1'b0;
    case (state_r)
      G_IDLE: begin
        timer_nxt_s = {TMR_W{1'b0}};
        if (entry_req && !full_s) begin
          state_nxt_s = G_OPEN;
        end else if (entry_req && full_s) begin
          rej_act_nxt_s = 1'b1;
          if (!rej_act_r) begin
            reject_nxt_s  = 1'b1;
            rej_div_nxt_s = 2'd1;
          end else begin
            reject_nxt_s  = (rej_div_r == 2'd0);
            rej_div_nxt_s = rej_div_r + 2'd1;
          end
        end else begin
          state_nxt_s = G_IDLE;
        end
      end
      G_OPEN: begin
        timer_nxt_s = timer_r + TMR_W'(1);
        if (entered) begin
          state_nxt_s = G_CLOSE;
        end else if (timer_r == TMR_LAST) begin
          timeout_nxt_s = 1'b1;
          state_nxt_s   = G_CLOSE;
        end else begin
          state_nxt_s = G_OPEN;
        end
      end
      G_CLOSE: state_nxt_s = G_IDLE;
      default: state_nxt_s = G_IDLE;
    endcase
  end

  // State, timer, divider and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= G_IDLE;
      timer_r     <= {TMR_W{1'b0}};
      rej_div_r   <= 2'd0;
      rej_act_r   <= 1'b0;
      gate_open_r <= 1'b0;
      reject_r    <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      timer_r     <= timer_nxt_s;
      rej_div_r   <= rej_div_nxt_s;
      rej_act_r   <= rej_act_nxt_s;
      gate_open_r <= (state_nxt_s == G_OPEN);
      reject_r    <= reject_nxt_s;
      timeout_r   <= timeout_nxt_s;
    end
  end

  assign full      = full_s;
  assign empty     = empty_s;
  assign gate_open = gate_open_r;
  assign reject    = reject_r;
  assign timeout   = timeout_r;

endmodule
